// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and display/LED outputs of the
// centisecond stopwatch, grouped for the display and LED muxes.
interface stopwatch_ctrl_if;
    logic        i_btnRun;
    logic        i_btnClear;
    logic [13:0] o_swData;
    logic [7:0]  o_swLED;

    modport master (
        output i_btnRun,
        output i_btnClear,
        input  o_swData,
        input  o_swLED
    );

    modport slave (
        input  i_btnRun,
        input  i_btnClear,
        output o_swData,
        output o_swLED
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: SS.CC stopwatch with debounced run/pause and
// clear/lap buttons, lap hold, sticky overflow and registered outputs.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic              sysclk,
    input logic              i_rst,
    stopwatch_ctrl_if.slave  sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE
    } state_t;

    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    lvl_q;
    logic [1:0]    lvlDly_q;
    logic [1:0]    pls_q;
    logic [DW-1:0] deb_q [2];

    logic          runP;
    logic          clrP;

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic [6:0]    cs_q;
    logic [6:0]    sec_q;
    logic [6:0]    lapCs_q;
    logic [6:0]    lapSec_q;
    logic          ovf_q;
    logic [13:0]   data_q;
    logic [7:0]    led_q;

    logic          counting;
    logic          tick;
    logic          wrap_d;
    logic [6:0]    cs_d;
    logic [6:0]    sec_d;
    logic [13:0]   live;
    logic [13:0]   lapVal;

    assign raw  = {sw.i_btnClear, sw.i_btnRun};
    assign runP = pls_q[0];
    assign clrP = pls_q[1];

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            lvlDly_q <= '0;
            pls_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            lvlDly_q <= lvl_q;
            pls_q    <= lvl_q & ~lvlDly_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (deb_q[i] == DEB_LAST) begin
                        lvl_q[i] <= sync2_q[i];
                        deb_q[i] <= '0;
                    end else begin
                        deb_q[i] <= deb_q[i] + 1'b1;
                    end
                end else begin
                    deb_q[i] <= '0;
                end
            end
        end
    end

    // Tick qualification, next SS.CC value and binary display values.
    always_comb begin
        counting = (state_q == RUN) || (state_q == LAP);
        tick     = counting && (pre_q == PRE_LAST);
        cs_d     = cs_q + 7'd1;
        sec_d    = sec_q;
        wrap_d   = 1'b0;
        if (cs_q == 7'd99) begin
            cs_d = 7'd0;
            if (sec_q == 7'd99) begin
                sec_d  = 7'd0;
                wrap_d = 1'b1;
            end else begin
                sec_d = sec_q + 7'd1;
            end
        end
        live   = 14'(sec_q) * 14'd100 + 14'(cs_q);
        lapVal = 14'(lapSec_q) * 14'd100 + 14'(lapCs_q);
    end

    // Mode FSM with prescaler, counter, lap latch and registered outputs.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cs_q     <= '0;
            sec_q    <= '0;
            lapCs_q  <= '0;
            lapSec_q <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            led_q    <= '0;
        end else begin
            data_q <= (state_q == LAP) ? lapVal : live;
            led_q  <= {5'b0, ovf_q, state_q == LAP, counting};

            if (state_q == IDLE) begin
                pre_q <= '0;
            end else if (counting) begin
                pre_q <= tick ? '0 : pre_q + 1'b1;
            end

            if (tick) begin
                cs_q  <= cs_d;
                sec_q <= sec_d;
                if (wrap_d) begin
                    ovf_q <= 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (runP) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (runP) begin
                        state_q <= PAUSE;
                    end else if (clrP) begin
                        state_q  <= LAP;
                        lapCs_q  <= cs_q;
                        lapSec_q <= sec_q;
                    end
                end
                LAP: begin
                    if (runP) begin
                        state_q <= PAUSE;
                    end else if (clrP) begin
                        state_q <= RUN;
                    end
                end
                PAUSE: begin
                    if (runP) begin
                        state_q <= RUN;
                    end else if (clrP) begin
                        state_q  <= IDLE;
                        pre_q    <= '0;
                        cs_q     <= '0;
                        sec_q    <= '0;
                        lapCs_q  <= '0;
                        lapSec_q <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sw.o_swData = data_q;
    assign sw.o_swLED  = led_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button presses against a
// tick-count reference model of the stopwatch.
module tb_stopwatch_ctrl;
    localparam int TICK = 4;
    localparam int DEB  = 3;
    localparam int LAT  = DEB + 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_LAP   = 2;
    localparam int S_PAUSE = 3;

    logic clk;
    logic i_rst;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sysclk (clk),
        .i_rst  (i_rst),
        .sw     (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int ecount = 0;
    int runAt  = -1;
    int clrAt  = -1;
    int m_st   = S_IDLE;
    int m_run  = 0;
    int m_lap  = 0;
    int m_data = 0;
    int m_led  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare both outputs.
    task automatic edge_step();
        bit rp;
        bit cp;
        int cur;
        @(posedge clk);
        ecount++;
        if (i_rst) begin
            m_st   = S_IDLE;
            m_run  = 0;
            m_lap  = 0;
            m_data = 0;
            m_led  = 0;
            runAt  = -1;
            clrAt  = -1;
        end else begin
            cur    = m_run / TICK;
            m_data = (m_st == S_LAP) ? m_lap : cur % 10000;
            m_led  = ((cur >= 10000) ? 4 : 0) +
                     ((m_st == S_LAP) ? 2 : 0) +
                     ((m_st == S_RUN || m_st == S_LAP) ? 1 : 0);
            rp = (runAt == ecount);
            cp = (clrAt == ecount);
            if (m_st == S_RUN || m_st == S_LAP) m_run++;
            case (m_st)
                S_IDLE: if (rp) m_st = S_RUN;
                S_RUN: begin
                    if (rp) m_st = S_PAUSE;
                    else if (cp) begin
                        m_st  = S_LAP;
                        m_lap = cur % 10000;
                    end
                end
                S_LAP: begin
                    if (rp) m_st = S_PAUSE;
                    else if (cp) m_st = S_RUN;
                end
                default: begin
                    if (rp) m_st = S_RUN;
                    else if (cp) begin
                        m_st  = S_IDLE;
                        m_run = 0;
                        m_lap = 0;
                    end
                end
            endcase
        end
        #1;
        check("data", 32'(sw_if.o_swData), 32'(m_data));
        check("led", 32'(sw_if.o_swLED), 32'(m_led));
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) edge_step();
    endtask

    task automatic press(input bit r, input bit c, input int hold);
        if (r) sw_if.i_btnRun = 1'b1;
        if (c) sw_if.i_btnClear = 1'b1;
        if (hold >= DEB) begin
            if (r) runAt = ecount + LAT;
            if (c) clrAt = ecount + LAT;
        end
        edges(hold);
        sw_if.i_btnRun   = 1'b0;
        sw_if.i_btnClear = 1'b0;
        edges(12);
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        edges(n);
        i_rst = 1'b0;
        if (sw_if.i_btnRun) runAt = ecount + LAT;
        if (sw_if.i_btnClear) clrAt = ecount + LAT;
    endtask

    task automatic wait_run(input int target);
        int g;
        g = 0;
        while (m_run != target && g < 60000) begin
            edge_step();
            g++;
        end
        check("wait_run_timeout", 32'(m_run), 32'(target));
    endtask

    int n;

    initial begin
        i_rst            = 1'b1;
        sw_if.i_btnRun   = 1'b0;
        sw_if.i_btnClear = 1'b0;

        do_reset(3);
        check("reset_data", 32'(sw_if.o_swData), 0);
        check("reset_led", 32'(sw_if.o_swLED), 0);

        sw_if.i_btnRun = 1'b1;
        do_reset(3);
        n = 0;
        while (sw_if.o_swLED[0] !== 1'b1 && n < 30) begin
            edge_step();
            n++;
        end
        check("press_latency", 32'(n), 32'(LAT + 1));
        edges(2);
        sw_if.i_btnRun = 1'b0;
        n = 0;
        while (m_data != 250 && n < 2000) begin
            edge_step();
            n++;
        end
        check("run250_data", 32'(sw_if.o_swData), 250);
        check("run250_led", 32'(sw_if.o_swLED), 8'h01);

        do_reset(3);
        press(1, 0, 10);
        wait_run(120 * TICK - (LAT - 1));
        press(0, 1, 10);
        edges(10);
        check("lap_freeze", 32'(sw_if.o_swData), 120);
        check("lap_led", 32'(sw_if.o_swLED), 8'h03);
        edges(100 * TICK);
        check("lap_hold", 32'(sw_if.o_swData), 120);
        press(0, 1, 10);
        check("lap_exit_led", 32'(sw_if.o_swLED), 8'h01);
        check("lap_exit_data", 32'(sw_if.o_swData), 32'(m_data));

        do_reset(2);
        press(1, 0, 5);
        i_rst = 1'b0;
        wait_run(10001 * TICK);
        edge_step();
        check("wrap_data", 32'(sw_if.o_swData), 1);
        check("wrap_ovf", 32'(sw_if.o_swLED[2]), 1);
        press(1, 0, 5);
        press(0, 1, 5);
        check("clear_data", 32'(sw_if.o_swData), 0);
        check("clear_led", 32'(sw_if.o_swLED), 0);
        press(0, 1, 5);
        check("idle_clr_data", 32'(sw_if.o_swData), 0);
        check("idle_clr_led", 32'(sw_if.o_swLED), 0);

        press(1, 0, 6);
        edges(2);
        i_rst = 1'b1;
        edges(2);
        i_rst = 1'b0;
        edges(20);
        check("rst_mid_deb", 32'(sw_if.o_swLED), 0);

        press(1, 0, 5);
        wait_run(37 * TICK - (LAT - 1) + 1);
        press(1, 0, 10);
        edges(100);
        check("pause_hold", 32'(sw_if.o_swData), 37);
        sw_if.i_btnRun = 1'b1;
        runAt = ecount + LAT;
        n = 0;
        while (sw_if.o_swData !== 14'd38 && n < 40) begin
            edge_step();
            n++;
        end
        sw_if.i_btnRun = 1'b0;
        check("resume_38", 32'(sw_if.o_swData), 38);
        check("resume_lat_ok", 32'(n <= LAT + TICK + 1), 1);
        edge_step();
        check("no_double", 32'(sw_if.o_swData), 38);
        edges(12);

        press(1, 0, 2);
        edges(10);
        check("glitch_led", 32'(sw_if.o_swLED), 8'h01);

        press(1, 0, 5);
        check("paused_led", 32'(sw_if.o_swLED), 8'h00);
        press(1, 1, 5);
        check("both_led", 32'(sw_if.o_swLED), 8'h01);
        check("both_keep", 32'(sw_if.o_swData != 0), 1);

        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 2);
            press(sel != 1, sel != 0, $urandom_range(1, 8));
            edges($urandom_range(0, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Centisecond stopwatch that feeds the display mux as one more 14-bit data source, beside the time-of-day clock and the up-counter. It takes two raw push-buttons, run/pause and clear/lap, and conditions them internally: synchronize, debounce, rising-edge detect. It counts SS.CC from 00.00 to 99.99 and presents the value as a binary number, SS*100+CC, which the FND display path already decodes into four digits. It also drives an 8-bit status LED vector for the LED mux.

## Interface
Parameters:
- TICK_DIV, 1_000_000: sysclk cycles per centisecond (100 MHz / 100).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles required before a button level is accepted (10 ms).

Ports:
- sysclk  in  1: system clock. The block has one clock.
- i_rst  in  1: reset, synchronous and active-high.
- i_btnRun  in  1: raw run/pause button, active-high, asynchronous to sysclk.
- i_btnClear  in  1: raw clear/lap button, active-high, asynchronous to sysclk.
- o_swData  out  14: displayed value, SS*100+CC, range 0..9999.
- o_swLED  out  8: [0] counting (RUN or LAP), [1] lap view active, [2] overflow (sticky), [7:3] always 0.

## Operation
- Button path, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The counter increments while the synchronized value differs from the debounced level and clears to 0 otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a 1-cycle pulse: runP or clrP.
- Prescaler (0..TICK_DIV-1):
  - Advances only in RUN or LAP.
  - Holds in PAUSE.
  - Cleared in IDLE.
  - Emits tick on wrap.
- Counter: cs (0..99) and sec (0..99).
  - On tick: cs+1. At cs=99, cs→0 and sec+1.
  - At 99.99, wraps to 00.00 and sets the overflow flag.
- FSM: IDLE, RUN, LAP, PAUSE.
  - IDLE: runP→RUN. clrP is ignored.
  - RUN: runP→PAUSE. clrP→LAP and latches {sec,cs} into the lap register.
  - LAP: counting continues and the display shows the lap register. clrP→RUN (live display). runP→PAUSE (live display).
  - PAUSE: runP→RUN. clrP→IDLE, which zeroes cs, sec, prescaler, lap register and the overflow flag.
- Simultaneous runP and clrP in one cycle: runP wins and clrP is discarded.
- A tick coincident with the runP that enters PAUSE still increments, because the increment is qualified by the current state.
- Overflow flag: set on wrap, cleared only by clear from PAUSE or by reset. A second wrap leaves it set.
- Output mux: o_swData = (state==LAP ? lap : live), computed as sec*100+cs with a 14-bit result and no truncation.

## Timing
- Reset values:
  - State IDLE.
  - cs, sec, lap, prescaler, debounce counters and debounced levels all 0.
  - o_swData = 0, o_swLED = 8'h00.
- A button held through reset is seen as a new press after reset deasserts.
- Press-to-pulse latency: the pulse appears DEBOUNCE_CYCLES+3 cycles after the raw input is sampled high: 2 synchronizer cycles, DEBOUNCE_CYCLES cycles of counting, 1 edge cycle.
- Bounce rejection: a raw change shorter than DEBOUNCE_CYCLES synchronized cycles never changes the level. Release is debounced the same way.
- State and counter update on the edge where the pulse or tick is high.
- o_swData and o_swLED are registered and follow internal state one cycle later.
- First tick after IDLE→RUN: exactly TICK_DIV cycles after the state becomes RUN.
- After PAUSE→RUN, the remaining prescaler count is used, so no partial tick is lost.
- Reset mid-count or mid-debounce: everything returns to reset values on the next edge. No pulse is generated from a partially debounced press.

## Test plan
Bench uses TICK_DIV=4 and DEBOUNCE_CYCLES=3.
- Reset with i_rst=1 for 3 cycles and both buttons low → o_swData=0 and o_swLED=0. Holding i_btnRun high through reset → one runP after release of i_rst, and the state goes to RUN.
- Run press held 10 cycles, then 250 ticks (1000 cycles) → o_swData=250, o_swLED=8'h01. Measured press-to-pulse latency = 6 cycles.
- Lap:
  - Run, clear press at count 120 → o_swData frozen at 120 and o_swLED=8'h03.
  - After 100 more ticks, clear press → o_swData=220, plus ticks elapsed during debounce, and o_swLED=8'h01.
- Wrap: run for 10001 ticks → o_swData=1 and o_swLED[2]=1. Pause then clear → o_swData=0 and o_swLED=8'h00. A further clear in IDLE has no effect.
- Pause/resume: pause at count 37 → o_swData stays 37 for 100 cycles. Resume → 38 occurs within at most TICK_DIV cycles, with no double increment.
- Glitches:
  - A 2-cycle pulse on i_btnRun produces no state change.
  - Both buttons debounced into the same cycle from PAUSE → state RUN and the count is retained, not cleared.
